// File: rtl/vqueue_flow_if.sv
// vqueue_flow_if: enqueue/dequeue handshake bundle for vqueue_flow.
//   enq_en/enq_msg  -> queue    enq_rdy         <- queue
//   deq_en          -> queue    deq_rdy/deq_msg <- queue
// Modports: master (producer/consumer side), slave (queue side).
interface vqueue_flow_if #(
  parameter int unsigned data_width = 32
);
  logic                  enq_en;
  logic                  enq_rdy;
  logic [data_width-1:0] enq_msg;
  logic                  deq_en;
  logic                  deq_rdy;
  logic [data_width-1:0] deq_msg;

  modport master (
    output enq_en, enq_msg, deq_en,
    input  enq_rdy, deq_rdy, deq_msg
  );

  modport slave (
    input  enq_en, enq_msg, deq_en,
    output enq_rdy, deq_rdy, deq_msg
  );
endinterface

// File: rtl/vqueue_flow.sv
// vqueue_flow: register-based FIFO with compile-time flow mode.
//   mode 0 normal : enq->deq latency 1.
//   mode 1 pipe   : enqueue accepted when full if a dequeue happens the same cycle.
//   mode 2 bypass : when empty, enq_msg passes straight to deq_msg in the same cycle.
// Any depth >= 1 (non-power-of-2 supported).
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous, active-high
//   count  entries currently stored (bypassed messages never counted)
//   err    sticky protocol-violation flag
//   q      vqueue_flow_if.slave handshake bundle
// Optional feature: define VQUEUE_FLOW_GUARD_EN to ignore en while rdy=0 and flag it on err.
// Without it, err is tied 0 and raw en drives the pointer/count logic.
module vqueue_flow #(
  parameter int unsigned data_width  = 32,
  parameter int unsigned num_entries = 2,
  parameter int unsigned mode        = 0,
  parameter int unsigned count_width = $clog2(num_entries + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [count_width-1:0] count,
  output logic                   err,
  vqueue_flow_if.slave           q
);

  localparam int unsigned addr_width = (num_entries == 1) ? 1 : $clog2(num_entries);
  localparam bit pipe_mode   = (mode == 1);
  localparam bit bypass_mode = (mode == 2);
  localparam logic [addr_width-1:0]  last_ptr   = addr_width'(num_entries - 1);
  localparam logic [count_width-1:0] full_count = count_width'(num_entries);

  if (mode > 2) begin : gen_bad_mode
    $error("vqueue_flow: illegal mode %0d (must be 0, 1 or 2)", mode);
  end

  logic [addr_width-1:0]  enq_ptr_q, enq_ptr_d;
  logic [addr_width-1:0]  deq_ptr_q, deq_ptr_d;
  logic [count_width-1:0] count_q, count_d;
  logic [data_width-1:0]  data_q [num_entries];
  logic [data_width-1:0]  head;

  logic empty, full;
  logic enq_fire, deq_fire;
  logic pass_through, do_write, do_read;

  assign empty = (count_q == '0);
  assign full  = (count_q == full_count);
  assign count = count_q;

  // Explicit compare mux keeps the read port clean for non-power-of-2 depths.
  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < num_entries; i++) begin
      if (deq_ptr_q == addr_width'(i)) head = data_q[i];
    end
  end

  always_comb begin
    q.enq_rdy = !full;
    if (pipe_mode) q.enq_rdy = !full | q.deq_en;
    q.deq_rdy = !empty;
    if (bypass_mode) q.deq_rdy = !empty | q.enq_en;
    q.deq_msg = head;
    if (bypass_mode && empty) q.deq_msg = q.enq_msg;
  end

`ifdef VQUEUE_FLOW_GUARD_EN
  logic err_q, err_d;

  assign enq_fire = q.enq_en & q.enq_rdy;
  assign deq_fire = q.deq_en & q.deq_rdy;
  assign err_d    = err_q | (q.enq_en & ~q.enq_rdy) | (q.deq_en & ~q.deq_rdy);
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign enq_fire = q.enq_en;
  assign deq_fire = q.deq_en;
  assign err      = 1'b0;
`endif

  // Bypass with an empty queue hands the message straight through; storage is untouched.
  assign pass_through = bypass_mode & empty & enq_fire & deq_fire;
  assign do_write     = enq_fire & ~pass_through;
  assign do_read      = deq_fire & ~pass_through;

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_write) enq_ptr_d = (enq_ptr_q == last_ptr) ? '0 : enq_ptr_q + addr_width'(1);
    if (do_read)  deq_ptr_d = (deq_ptr_q == last_ptr) ? '0 : deq_ptr_q + addr_width'(1);
    case ({do_write, do_read})
      2'b10:   count_d = count_q + count_width'(1);
      2'b01:   count_d = count_q - count_width'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Payload storage is not reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < num_entries; i++) begin
      if (do_write && enq_ptr_q == addr_width'(i)) data_q[i] <= q.enq_msg;
    end
  end

endmodule

// File: tb/tb_vqueue_flow.sv
// tb_vqueue_flow: directed bench for vqueue_flow across depths and flow modes.
// Instances: u_t1 (N=2,mode 0), u_t2 (N=3,mode 0), u_t3 (N=2,mode 1),
//            u_t4 (N=2,mode 2), u_t6 (N=1,mode 0). All share clk/reset.
module tb_vqueue_flow;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  vqueue_flow_if #(.data_width(8)) i1 ();
  vqueue_flow_if #(.data_width(8)) i2 ();
  vqueue_flow_if #(.data_width(8)) i3 ();
  vqueue_flow_if #(.data_width(8)) i4 ();
  vqueue_flow_if #(.data_width(8)) i6 ();

  logic [1:0] cnt1, cnt2, cnt3, cnt4;
  logic       cnt6;
  logic       err1, err2, err3, err4, err6;

  vqueue_flow #(.data_width(8), .num_entries(2), .mode(0)) u_t1 (
    .clk(clk), .reset(reset), .count(cnt1), .err(err1), .q(i1));
  vqueue_flow #(.data_width(8), .num_entries(3), .mode(0)) u_t2 (
    .clk(clk), .reset(reset), .count(cnt2), .err(err2), .q(i2));
  vqueue_flow #(.data_width(8), .num_entries(2), .mode(1)) u_t3 (
    .clk(clk), .reset(reset), .count(cnt3), .err(err3), .q(i3));
  vqueue_flow #(.data_width(8), .num_entries(2), .mode(2)) u_t4 (
    .clk(clk), .reset(reset), .count(cnt4), .err(err4), .q(i4));
  vqueue_flow #(.data_width(8), .num_entries(1), .mode(0)) u_t6 (
    .clk(clk), .reset(reset), .count(cnt6), .err(err6), .q(i6));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    {i1.enq_en, i1.deq_en, i2.enq_en, i2.deq_en, i3.enq_en, i3.deq_en} = '0;
    {i4.enq_en, i4.deq_en, i6.enq_en, i6.deq_en} = '0;
    {i1.enq_msg, i2.enq_msg, i3.enq_msg, i4.enq_msg, i6.enq_msg} = '0;
    do_reset();

    // T1: N=2 normal fill/drain
    check_eq("t1_rst_count", cnt1, 0);
    check_eq("t1_rst_enq_rdy", i1.enq_rdy, 1);
    check_eq("t1_rst_deq_rdy", i1.deq_rdy, 0);
    check_eq("t1_rst_err", err1, 0);
    i1.enq_en = 1; i1.enq_msg = 8'h0A; step();
    check_eq("t1_count1", cnt1, 1);
    check_eq("t1_deq_rdy1", i1.deq_rdy, 1);
    i1.enq_msg = 8'h0B; step();
    i1.enq_en = 0; #1;
    check_eq("t1_count2", cnt1, 2);
    check_eq("t1_full_enq_rdy", i1.enq_rdy, 0);
    i1.deq_en = 1; #1;
    check_eq("t1_deq_a", i1.deq_msg, 8'h0A);
    step();
    check_eq("t1_deq_b", i1.deq_msg, 8'h0B);
    check_eq("t1_count_dec", cnt1, 1);
    step();
    i1.deq_en = 0; #1;
    check_eq("t1_empty_count", cnt1, 0);
    check_eq("t1_empty_deq_rdy", i1.deq_rdy, 0);

    // T2: N=3 streaming, one in flight, pointers wrap
    i2.enq_en = 1; i2.enq_msg = 8'd1; step();
    for (int k = 2; k <= 7; k++) begin
      i2.enq_msg = 8'(k); i2.deq_en = 1; #1;
      check_eq($sformatf("t2_deq_%0d", k - 1), i2.deq_msg, 32'(k - 1));
      step();
      check_eq($sformatf("t2_count_%0d", k), cnt2, 1);
    end
    i2.enq_en = 0; #1;
    check_eq("t2_deq_7", i2.deq_msg, 7);
    step();
    i2.deq_en = 0; #1;
    check_eq("t2_drained", cnt2, 0);

    // T3: N=2 pipe, enqueue while full with same-cycle dequeue
    i3.enq_en = 1; i3.enq_msg = 8'h1; step();
    i3.enq_msg = 8'h2; step();
    i3.enq_en = 0; #1;
    check_eq("t3_full_enq_rdy", i3.enq_rdy, 0);
    i3.enq_en = 1; i3.enq_msg = 8'h3; i3.deq_en = 1; #1;
    check_eq("t3_pipe_enq_rdy", i3.enq_rdy, 1);
    check_eq("t3_pipe_deq", i3.deq_msg, 8'h1);
    step();
    i3.enq_en = 0; #1;
    check_eq("t3_count_stays", cnt3, 2);
    check_eq("t3_deq_2", i3.deq_msg, 8'h2);
    step();
    check_eq("t3_deq_3", i3.deq_msg, 8'h3);
    step();
    i3.deq_en = 0; #1;
    check_eq("t3_drained", cnt3, 0);

    // T4: N=2 bypass
    check_eq("t4_idle_deq_rdy", i4.deq_rdy, 0);
    i4.enq_en = 1; i4.enq_msg = 8'h55; i4.deq_en = 1; #1;
    check_eq("t4_byp_deq_rdy", i4.deq_rdy, 1);
    check_eq("t4_byp_msg", i4.deq_msg, 8'h55);
    step();
    check_eq("t4_byp_count", cnt4, 0);
    i4.deq_en = 0; i4.enq_msg = 8'h66; step();
    i4.enq_en = 0; i4.enq_msg = 8'h77; #1;
    check_eq("t4_count1", cnt4, 1);
    check_eq("t4_stored_msg", i4.deq_msg, 8'h66);
    check_eq("t4_stored_rdy", i4.deq_rdy, 1);
    i4.deq_en = 1; step();
    i4.deq_en = 0; #1;
    check_eq("t4_drained", cnt4, 0);

    // T5: reset beats simultaneous enq/deq
    i1.enq_en = 1; i1.enq_msg = 8'h11; step();
    i1.enq_msg = 8'h22; step();
    check_eq("t5_count2", cnt1, 2);
    reset = 1; i1.enq_en = 1; i1.deq_en = 1; step();
    reset = 0; i1.enq_en = 0; i1.deq_en = 0; #1;
    check_eq("t5_rst_count", cnt1, 0);
    check_eq("t5_rst_enq_rdy", i1.enq_rdy, 1);
    check_eq("t5_rst_err", err1, 0);

    // T6: N=1, illegal enqueue while full
    i6.enq_en = 1; i6.enq_msg = 8'h9; step();
    i6.enq_en = 0; #1;
    check_eq("t6_full", cnt6, 1);
    check_eq("t6_full_enq_rdy", i6.enq_rdy, 0);
    i6.enq_en = 1; i6.enq_msg = 8'h7; step();
    i6.enq_en = 0; #1;
`ifdef VQUEUE_FLOW_GUARD_EN
    check_eq("t6_err_set", err6, 1);
    check_eq("t6_count_kept", cnt6, 1);
    check_eq("t6_msg_kept", i6.deq_msg, 8'h9);
    i6.deq_en = 1; step();
    i6.deq_en = 0; step();
    check_eq("t6_err_sticky", err6, 1);
    check_eq("t6_count0", cnt6, 0);
`else
    check_eq("t6_err_tied", err6, 0);
`endif
    do_reset();
    check_eq("t6_rst_err", err6, 0);
    check_eq("t6_rst_count", cnt6, 0);
    i6.enq_en = 1; i6.enq_msg = 8'h9; step();
    i6.enq_en = 0; i6.deq_en = 1; #1;
    check_eq("t6_deq_9", i6.deq_msg, 8'h9);
    step();
    i6.deq_en = 0; #1;
    check_eq("t6_drained", cnt6, 0);
    check_eq("t6_err_final", err6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
